// File: rtl/ysyx_23060203_axi_rd_sram.sv
// AXI4 read responder over a word-addressed SRAM array.
// FSM: IDLE accepts AR, WAIT counts first-beat latency, BURST streams beats
// (FIXED/INCR/WRAP). Separate byte-strobed loader path into the array.
module ysyx_23060203_axi_rd_sram #(
  parameter logic [31:0] BASE  = 32'h8000_0000,
  parameter int          DEPTH = 1024,
  parameter int          LAT   = 2,
  localparam int         IW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_arvalid,
  output logic          in_arready,
  input  logic [31:0]   in_araddr,
  input  logic [3:0]    in_arid,
  input  logic [7:0]    in_arlen,
  input  logic [2:0]    in_arsize,
  input  logic [1:0]    in_arburst,
  output logic          in_rvalid,
  input  logic          in_rready,
  output logic [31:0]   in_rdata,
  output logic [1:0]    in_rresp,
  output logic          in_rlast,
  output logic [3:0]    in_rid,
  input  logic          pl_we,
  input  logic [IW-1:0] pl_addr,
  input  logic [31:0]   pl_wdata,
  input  logic [3:0]    pl_wstrb
);

  localparam logic [1:0]  S_IDLE  = 2'd0;
  localparam logic [1:0]  S_WAIT  = 2'd1;
  localparam logic [1:0]  S_BURST = 2'd2;
  // One past the last mapped byte; 33 bits so BASE near the top cannot wrap.
  localparam logic [32:0] LIMIT   = {1'b0, BASE} + 33'(DEPTH) * 33'd4;

  logic [31:0] mem [DEPTH];

  logic [1:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  id_q, id_d;
  logic [7:0]  len_q, len_d;
  logic [2:0]  size_q, size_d;
  logic [1:0]  burst_q, burst_d;
  logic [7:0]  beat_q, beat_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        berr_q, berr_d;

  logic [31:0] step, bound, addr_nxt, off;
  logic [IW-1:0] idx;
  logic        in_range, beat_err, active, ar_err;

  // Preload writes, byte-lane masked; independent of the read FSM.
  always_ff @(posedge clock) begin
    if (pl_we) begin
      for (int i = 0; i < 4; i++)
        if (pl_wstrb[i]) mem[pl_addr][8*i +: 8] <= pl_wdata[8*i +: 8];
    end
  end

  // Burst address arithmetic, range check and read-channel outputs.
  always_comb begin
    step  = 32'd1 << size_q;
    bound = ({24'd0, len_q} + 32'd1) << size_q;
    case (burst_q)
      2'b00:   addr_nxt = addr_q;
      2'b10:   addr_nxt = (addr_q & ~(bound - 32'd1)) | ((addr_q + step) & (bound - 32'd1));
      default: addr_nxt = addr_q + step;
    endcase
    in_range = (addr_q >= BASE) && ({1'b0, addr_q} < LIMIT);
    off      = addr_q - BASE;
    idx      = IW'(off >> 2);
    beat_err = berr_q || !in_range;
    // Reset masks the outputs in the same cycle so nothing leaks while it is held.
    active     = (state_q == S_BURST) && !reset;
    in_arready = (state_q == S_IDLE) && !reset;
    in_rvalid  = active;
    in_rlast   = active && (beat_q == len_q);
    in_rid     = active ? id_q : 4'd0;
    in_rresp   = (active && beat_err) ? 2'b10 : 2'b00;
    in_rdata   = (active && !beat_err) ? mem[idx] : 32'd0;
    // Burst-wide errors are decided once from the AR request.
    ar_err = (in_arburst == 2'b11) || (in_arsize > 3'd2) ||
             ((in_arburst == 2'b10) && (in_arlen != 8'd1) && (in_arlen != 8'd3) &&
              (in_arlen != 8'd7) && (in_arlen != 8'd15));
  end

  // Next-state logic: IDLE accepts AR, WAIT counts latency, BURST streams beats.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    id_d    = id_q;
    len_d   = len_q;
    size_d  = size_q;
    burst_d = burst_q;
    beat_d  = beat_q;
    cnt_d   = cnt_q;
    berr_d  = berr_q;
    case (state_q)
      S_IDLE: begin
        if (in_arvalid) begin
          addr_d  = in_araddr;
          id_d    = in_arid;
          len_d   = in_arlen;
          size_d  = in_arsize;
          burst_d = in_arburst;
          beat_d  = 8'd0;
          berr_d  = ar_err;
          if (LAT > 0) begin
            cnt_d   = 4'(LAT - 1);
            state_d = S_WAIT;
          end else begin
            state_d = S_BURST;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_BURST;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_BURST: begin
        if (in_rready) begin
          if (beat_q == len_q) begin
            state_d = S_IDLE;
          end else begin
            beat_d = beat_q + 8'd1;
            addr_d = addr_nxt;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset abandons any in-flight burst.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= 32'd0;
      id_q    <= 4'd0;
      len_q   <= 8'd0;
      size_q  <= 3'd0;
      burst_q <= 2'd0;
      beat_q  <= 8'd0;
      cnt_q   <= 4'd0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      id_q    <= id_d;
      len_q   <= len_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      beat_q  <= beat_d;
      cnt_q   <= cnt_d;
      berr_q  <= berr_d;
    end
  end

endmodule
